// File: rtl/seq_div4.sv
// Sequential 4-bit unsigned restoring divider: one quotient bit per clock, done pulse on result.
// Optional macro DIV4_ZERO_DETECT_EN adds the div0 port and a fast path for divisor zero.
module seq_div4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder
`ifdef DIV4_ZERO_DETECT_EN
    ,
    output logic       div0
`endif
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e     state_q;
    logic [3:0] q_q;
    logic [3:0] d_q;
    logic [4:0] r_q;
    logic [1:0] cnt_q;

    logic [4:0] r_shift;
    logic [4:0] diff;
    logic       no_borrow;
    logic [4:0] r_next;
    logic [3:0] q_next;

    // One restoring step on the {R,Q} pair; carry-out of R - D means no borrow.
    always_comb begin
        r_shift             = (r_q << 1) | {4'b0000, q_q[3]};
        {no_borrow, diff}   = {1'b0, r_shift} + {1'b0, ~{1'b0, d_q}} + 6'd1;
        r_next              = no_borrow ? diff : r_shift;
        q_next              = {q_q[2:0], no_borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            q_q       <= 4'h0;
            d_q       <= 4'h0;
            r_q       <= 5'h00;
            cnt_q     <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= 4'h0;
            remainder <= 4'h0;
`ifdef DIV4_ZERO_DETECT_EN
            div0      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        q_q   <= dividend;
                        d_q   <= divisor;
                        r_q   <= 5'h00;
                        cnt_q <= 2'd3;
`ifdef DIV4_ZERO_DETECT_EN
                        div0  <= 1'b0;
                        if (divisor == 4'h0) begin
                            quotient  <= 4'hF;
                            remainder <= dividend;
                            div0      <= 1'b1;
                            done      <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            busy    <= 1'b1;
                            state_q <= StCalc;
                        end
`else
                        busy    <= 1'b1;
                        state_q <= StCalc;
`endif
                    end
                end
                StCalc: begin
                    q_q   <= q_next;
                    r_q   <= r_next;
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd0) begin
                        quotient  <= q_next;
                        remainder <= r_next[3:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div4.sv
// Scoreboard bench for seq_div4: stimulus pushes expected results, a negedge monitor pops on done.
module tb_seq_div4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dividend = 4'h0;
    logic [3:0] divisor = 4'h0;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
`ifdef DIV4_ZERO_DETECT_EN
    logic       div0;
`endif

    seq_div4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV4_ZERO_DETECT_EN
        ,
        .div0      (div0)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t popped;
    int errors = 0;
    int checks = 0;

    // Model of the block's externally visible timeline, owned by the stimulus side.
    int free_cyc = 0;
    int busy_lo = -100;
    int busy_hi = -100;
    int done_at = -100;
    int z_clear_at = -100;

    // Output values the monitor expects to see held between results.
    logic [3:0] hold_q = 4'h0;
    logic [3:0] hold_r = 4'h0;
    logic       hold_z = 1'b0;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            hold_q = 4'h0;
            hold_r = 4'h0;
            hold_z = 1'b0;
        end else begin
            if (cyc == z_clear_at) hold_z = 1'b0;
            chk("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
            chk("done", int'(done), int'(cyc == done_at));
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    popped = sb.pop_front();
                    chk("done_cycle", cyc, popped.at);
                    hold_q = popped.q;
                    hold_r = popped.r;
                    hold_z = popped.z;
                end
            end
            chk("quotient", int'(quotient), int'(hold_q));
            chk("remainder", int'(remainder), int'(hold_r));
`ifdef DIV4_ZERO_DETECT_EN
            chk("div0", int'(div0), int'(hold_z));
`endif
        end
    end

    // Drive one cycle of inputs; if the block is idle and start is high, predict the result.
    task automatic issue(input logic s, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        logic skip;
        @(posedge clk);
        #1;
        start    = s;
        dividend = a;
        divisor  = b;
        if (s && cyc >= free_cyc) begin
            skip = 1'b0;
`ifdef DIV4_ZERO_DETECT_EN
            skip = (b == 4'h0);
`endif
            e.q = (b == 4'h0) ? 4'hF : a / b;
            e.r = (b == 4'h0) ? a : a % b;
            e.z = skip;
            if (skip) begin
                e.at     = cyc + 1;
                free_cyc = cyc + 2;
                busy_lo  = -100;
                busy_hi  = -100;
            end else begin
                e.at     = cyc + 5;
                free_cyc = cyc + 6;
                busy_lo  = cyc + 1;
                busy_hi  = cyc + 4;
            end
            done_at    = e.at;
            z_clear_at = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] b);
        issue(1'b1, a, b);
        repeat (5) issue(1'b0, 4'($urandom), 4'($urandom));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        start   = 1'b0;
        busy_lo = -100;
        busy_hi = -100;
        done_at = -100;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quotient", int'(quotient), 0);
        chk("rst_remainder", int'(remainder), 0);
`ifdef DIV4_ZERO_DETECT_EN
        chk("rst_div0", int'(div0), 0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        free_cyc = cyc;
    endtask

    initial begin
        do_reset();

        run(4'd13, 4'd3);
        run(4'd15, 4'd1);
        run(4'd2, 4'd7);
        run(4'd15, 4'd15);
        run(4'd9, 4'd0);
        run(4'd6, 4'd2);

        // start held high: second request accepted only once the block is idle again
        issue(1'b1, 4'd13, 4'd3);
        repeat (6) issue(1'b1, 4'd14, 4'd5);
        repeat (6) issue(1'b0, 4'd0, 4'd0);

        // reset in the middle of a division discards it
        issue(1'b1, 4'd13, 4'd3);
        issue(1'b0, 4'd0, 4'd0);
        do_reset();
        run(4'd7, 4'd2);

        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run(4'(a), 4'(b));
            end
        end

        repeat (300) issue($urandom_range(0, 2) == 0, 4'($urandom), 4'($urandom));
        repeat (8) issue(1'b0, 4'd0, 4'd0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
